// File: rtl/axi_node_pkg.sv
// Shared AXI node types: W-channel destination router FSM state.
package axi_node_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_ERR_SINK = 2'd1,
    ST_ERR_DONE = 2'd2
  } w_state_e;

endpackage

// File: rtl/axi_w_dest_fifo.sv
// Circular FIFO of one-hot W destinations; count is $clog2(DEPTH)+1 bits wide.
module axi_w_dest_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_w_dest_router.sv
// Routes target-side W beats to the initiator port at the head of the destination FIFO.
// Optional macro AXI_W_DEST_BYPASS_EN: a push into an empty FIFO routes in the same cycle.
module axi_w_dest_router
  import axi_node_pkg::*;
#(
  parameter int unsigned N_INIT_PORT = 8,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_dest_i,
  input  logic [N_INIT_PORT-1:0]    dest_i,
  output logic                      grant_fifo_dest_o,
  input  logic                      wvalid_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   wstrb_i,
  input  logic                      wlast_i,
  output logic                      wready_o,
  output logic [N_INIT_PORT-1:0]    wvalid_o,
  output logic [DATA_WIDTH-1:0]     wdata_o,
  output logic [DATA_WIDTH/8-1:0]   wstrb_o,
  output logic                      wlast_o,
  input  logic [N_INIT_PORT-1:0]    wready_i,
  input  logic                      handle_error_i,
  output logic                      wdata_error_completed_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  w_state_e               state_q, state_d;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [N_INIT_PORT-1:0] fifo_head, route_head;
  logic [CW-1:0]          fifo_count;
  logic                   bypass, route_valid, w_hs;

  axi_w_dest_fifo #(
    .WIDTH (N_INIT_PORT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (dest_i),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign grant_fifo_dest_o = ~fifo_full;
  assign wdata_o = wdata_i;
  assign wstrb_o = wstrb_i;
  assign wlast_o = wlast_i;

`ifdef AXI_W_DEST_BYPASS_EN
  assign bypass = fifo_empty & (state_q == ST_NORMAL) & push_dest_i;
`else
  assign bypass = 1'b0;
`endif

  assign route_head  = bypass ? dest_i : fifo_head;
  assign route_valid = ~fifo_empty | bypass;
  assign w_hs        = wvalid_i & wready_o;

  // A bypassed destination consumed by a last beat never needs to be stored.
  assign fifo_pop  = (state_q == ST_NORMAL) & ~fifo_empty & w_hs & wlast_i;
  assign fifo_push = push_dest_i & grant_fifo_dest_o & ~(bypass & w_hs & wlast_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_NORMAL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL:   if (handle_error_i && fifo_count == '0) state_d = ST_ERR_SINK;
      ST_ERR_SINK: if (wvalid_i && wlast_i) state_d = ST_ERR_DONE;
      ST_ERR_DONE: state_d = ST_NORMAL;
      default:     state_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    wvalid_o                = '0;
    wready_o                = 1'b0;
    wdata_error_completed_o = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (route_valid) begin
          wvalid_o = {N_INIT_PORT{wvalid_i}} & route_head;
          wready_o = |(route_head & wready_i);
        end
      end
      ST_ERR_SINK: wready_o = 1'b1;
      ST_ERR_DONE: wdata_error_completed_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_w_dest_router.sv
// Self-checking bench for axi_w_dest_router against a queue-based reference model.
module tb_axi_w_dest_router;

  localparam int N  = 8;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int D  = 4;
`ifdef AXI_W_DEST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push_dest_i;
  logic [N-1:0]  dest_i;
  logic          grant_fifo_dest_o;
  logic          wvalid_i;
  logic [DW-1:0] wdata_i;
  logic [SW-1:0] wstrb_i;
  logic          wlast_i;
  logic          wready_o;
  logic [N-1:0]  wvalid_o;
  logic [DW-1:0] wdata_o;
  logic [SW-1:0] wstrb_o;
  logic          wlast_o;
  logic [N-1:0]  wready_i;
  logic          handle_error_i;
  logic          wdata_error_completed_o;

  int tests = 0;
  int fails = 0;

  axi_w_dest_router #(
    .N_INIT_PORT (N),
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .push_dest_i             (push_dest_i),
    .dest_i                  (dest_i),
    .grant_fifo_dest_o       (grant_fifo_dest_o),
    .wvalid_i                (wvalid_i),
    .wdata_i                 (wdata_i),
    .wstrb_i                 (wstrb_i),
    .wlast_i                 (wlast_i),
    .wready_o                (wready_o),
    .wvalid_o                (wvalid_o),
    .wdata_o                 (wdata_o),
    .wstrb_o                 (wstrb_o),
    .wlast_o                 (wlast_o),
    .wready_i                (wready_i),
    .handle_error_i          (handle_error_i),
    .wdata_error_completed_o (wdata_error_completed_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending destinations in arrival order, plus error-handling phase.
  logic [N-1:0] q[$];
  bit sinking = 0;
  bit done    = 0;

  always @(negedge clk) begin
    logic [N-1:0] head, e_wv;
    logic         e_wr, e_cmp, hv, byp, hs;
    if (!rst_n) begin
      q.delete();
      sinking = 0;
      done    = 0;
      chk("rst_grant", grant_fifo_dest_o, 1'b1);
      chk("rst_wvalid", wvalid_o, '0);
      chk("rst_wready", wready_o, 1'b0);
      chk("rst_cmp", wdata_error_completed_o, 1'b0);
    end else begin
      hv    = q.size() != 0;
      byp   = BYP && !sinking && !done && q.size() == 0 && push_dest_i;
      head  = hv ? q[0] : (byp ? dest_i : '0);
      e_wv  = '0;
      e_wr  = 1'b0;
      e_cmp = 1'b0;
      if (sinking) e_wr = 1'b1;
      else if (done) e_cmp = 1'b1;
      else begin
        e_wv = wvalid_i ? head : '0;
        e_wr = |(head & wready_i);
      end
      chk("grant", grant_fifo_dest_o, q.size() != D);
      chk("wvalid", wvalid_o, e_wv);
      chk("wready", wready_o, e_wr);
      chk("completed", wdata_error_completed_o, e_cmp);
      chk("wdata", wdata_o, wdata_i);
      chk("wstrb", wstrb_o, wstrb_i);
      chk("wlast", wlast_o, wlast_i);
      hs = wvalid_i && e_wr;
      if (sinking) begin
        if (wvalid_i && wlast_i) begin sinking = 0; done = 1; end
      end else if (done) begin
        done = 0;
      end else if (handle_error_i && q.size() == 0) begin
        sinking = 1;
      end
      if (push_dest_i && q.size() != D && !(byp && hs && wlast_i)) begin
        if (hv && hs && wlast_i && !e_cmp) void'(q.pop_front());
        q.push_back(dest_i);
      end else if (hv && hs && wlast_i && e_cmp == 1'b0 && e_wv != '0) begin
        void'(q.pop_front());
      end
    end
  end

  task automatic drive(input logic push, input logic [N-1:0] dst, input logic wv,
                       input logic wl, input logic [N-1:0] wr, input logic herr);
    @(posedge clk);
    #1;
    push_dest_i    = push;
    dest_i         = dst;
    wvalid_i       = wv;
    wlast_i        = wl;
    wready_i       = wr;
    handle_error_i = herr;
    wdata_i        = {$urandom, $urandom};
    wstrb_i        = SW'($urandom);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    push_dest_i = 0; dest_i = '0; wvalid_i = 0; wdata_i = '0; wstrb_i = '0;
    wlast_i = 0; wready_i = '0; handle_error_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single destination, 4-beat burst to port 2.
    drive(1'b1, 8'h04, 1'b0, 1'b0, 8'h04, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1, k == 3, 8'h04, 1'b0);
      @(negedge clk);
      chk("s1_wvalid", wvalid_o, 8'h04);
      chk("s1_hs", wready_o, 1'b1);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 8'hFF, 1'b0);
    @(negedge clk);
    chk("s1_empty_wvalid", wvalid_o, 8'h00);
    chk("s1_empty_wready", wready_o, 1'b0);

    // Fill the FIFO, overflow push, then pop with a push while full.
    for (int k = 0; k < 4; k++) drive(1'b1, 8'h01 << k, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 8'h80, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("s2_full_grant", grant_fifo_dest_o, 1'b0);
    drive(1'b1, 8'h40, 1'b1, 1'b1, 8'hFF, 1'b0);
    @(negedge clk);
    chk("s2_head0", wvalid_o, 8'h01);
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, '0, 1'b1, 1'b1, 8'hFF, 1'b0);
      @(negedge clk);
      chk("s2_drain", wvalid_o, 8'h01 << k);
    end
    drive(1'b0, '0, 1'b1, 1'b1, 8'hFF, 1'b0);
    @(negedge clk);
    chk("s2_empty_after", wvalid_o, 8'h00);

    // Port 0 then port 5, two beats each, pointers already wrapped.
    drive(1'b1, 8'h01, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 8'h20, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1, k[0], 8'hFF, 1'b0);
      @(negedge clk);
      chk("s3_order", wvalid_o, (k < 2) ? 8'h01 : 8'h20);
    end

    // Error with one burst pending: drain first, then sink 3 beats.
    drive(1'b1, 8'h02, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, '0, 1'b1, k == 1, 8'h02, 1'b1);
      @(negedge clk);
      chk("s4_drain", wvalid_o, 8'h02);
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    chk("s4_pre_sink", wready_o, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1, k == 2, 8'hFF, 1'b0);
      @(negedge clk);
      chk("s4_sink_rdy", wready_o, 1'b1);
      chk("s4_sink_vld", wvalid_o, 8'h00);
    end
    idle();
    @(negedge clk);
    chk("s4_pulse", wdata_error_completed_o, 1'b1);
    idle();
    @(negedge clk);
    chk("s4_pulse_end", wdata_error_completed_o, 1'b0);

    // Asynchronous reset mid-burst with three destinations queued.
    for (int k = 0; k < 3; k++) drive(1'b1, 8'h10, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 8'hFF, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("s5_rst_wvalid", wvalid_o, 8'h00);
    chk("s5_rst_grant", grant_fifo_dest_o, 1'b1);
    chk("s5_rst_wready", wready_o, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0, 8'hFF, 1'b0);
    @(negedge clk);
    chk("s5_flushed", wvalid_o, 8'h00);

    // Push into empty FIFO with a same-cycle single-beat burst.
    drive(1'b1, 8'h08, 1'b1, 1'b1, 8'hFF, 1'b0);
    @(negedge clk);
    chk("s6_same_cycle", wvalid_o, BYP ? 8'h08 : 8'h00);
    drive(1'b0, '0, 1'b1, 1'b1, 8'hFF, 1'b0);
    @(negedge clk);
    chk("s6_next_cycle", wvalid_o, BYP ? 8'h00 : 8'h08);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 2) == 0, 8'h01 << $urandom_range(0, N - 1),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            N'($urandom), $urandom_range(0, 40) == 0);
    end
    idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
